// File: rtl/ccff_chain_loader.sv
// rtl/ccff_chain_loader.sv - Configuration-chain loader: serialises bitstream words into a ccff chain
// and optionally recirculates it once to check the loaded ones-count.
module ccff_chain_loader #(
    parameter int CHAIN_LEN = 9,
    parameter int WORD_W    = 8,
    parameter int CNT_W     = $clog2(CHAIN_LEN + 1)
) (
    input  logic              prog_clk,
    input  logic              prog_reset,
    input  logic              cfg_start,
    input  logic              cfg_verify_en,
    input  logic [WORD_W-1:0] cfg_word,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    output logic              ccff_head,
    input  logic              ccff_tail,
    output logic              ccff_clk_en,
    output logic              cfg_busy,
    output logic              cfg_done,
    output logic              cfg_pass
);

    localparam int                IDX_W    = (WORD_W > 1) ? $clog2(WORD_W) : 1;
    localparam logic [IDX_W-1:0]  IDX_LAST = IDX_W'(WORD_W - 1);
    localparam logic [CNT_W-1:0]  CNT_FULL = CNT_W'(CHAIN_LEN);

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_VERIFY, S_DONE} state_t;

    state_t              state_q, state_d;
    logic [WORD_W-1:0]   buf_q, buf_d;
    logic                buf_vld_q, buf_vld_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic [CNT_W-1:0]    bit_cnt_q, bit_cnt_d;
    logic [CNT_W-1:0]    vcnt_q, vcnt_d;
    logic [CNT_W-1:0]    ones_load_q, ones_load_d;
    logic [CNT_W-1:0]    ones_ver_q, ones_ver_d;
    logic                verify_q, verify_d;
    logic                head_q, head_d;
    logic                load_en_q, load_en_d;
    logic                done_q, done_d;
    logic                pass_q, pass_d;
    logic                accept;

    assign cfg_ready   = (state_q == S_LOAD) && !buf_vld_q && (bit_cnt_q != CNT_FULL);
    assign accept      = cfg_valid && cfg_ready;
    // During VERIFY the chain is closed on itself, so the tail feeds the head without a register stage.
    assign ccff_head   = (state_q == S_VERIFY) ? ccff_tail : head_q;
    assign ccff_clk_en = load_en_q || (state_q == S_VERIFY);
    assign cfg_busy    = (state_q == S_LOAD) || (state_q == S_VERIFY);
    assign cfg_done    = done_q;
    assign cfg_pass    = pass_q;

    always_comb begin
        state_d     = state_q;
        buf_d       = buf_q;
        buf_vld_d   = buf_vld_q;
        idx_d       = idx_q;
        bit_cnt_d   = bit_cnt_q;
        vcnt_d      = vcnt_q;
        ones_load_d = ones_load_q;
        ones_ver_d  = ones_ver_q;
        verify_d    = verify_q;
        head_d      = head_q;
        load_en_d   = 1'b0;
        done_d      = done_q;
        pass_d      = pass_q;

        case (state_q)
            S_IDLE, S_DONE: begin
                if (cfg_start) begin
                    state_d     = S_LOAD;
                    done_d      = 1'b0;
                    pass_d      = 1'b0;
                    bit_cnt_d   = '0;
                    vcnt_d      = '0;
                    ones_load_d = '0;
                    ones_ver_d  = '0;
                    verify_d    = cfg_verify_en;
                    buf_vld_d   = 1'b0;
                    idx_d       = '0;
                end
            end
            S_LOAD: begin
                if (buf_vld_q && (bit_cnt_q != CNT_FULL)) begin
                    head_d      = buf_q[idx_q];
                    load_en_d   = 1'b1;
                    bit_cnt_d   = bit_cnt_q + CNT_W'(1);
                    ones_load_d = ones_load_q + CNT_W'(buf_q[idx_q]);
                    idx_d       = idx_q + IDX_W'(1);
                    // Leftover bits of the final word are dropped once the chain is full.
                    if ((idx_q == IDX_LAST) || (bit_cnt_d == CNT_FULL)) begin
                        buf_vld_d = 1'b0;
                        idx_d     = '0;
                    end
                end else if (accept) begin
                    buf_d     = cfg_word;
                    buf_vld_d = 1'b1;
                    idx_d     = '0;
                end
                // Leave only after the cycle presenting the last bit, so its shift edge still sees LOAD data.
                if (bit_cnt_q == CNT_FULL) begin
                    if (verify_q) begin
                        state_d = S_VERIFY;
                    end else begin
                        state_d = S_DONE;
                        done_d  = 1'b1;
                        pass_d  = 1'b1;
                    end
                end
            end
            S_VERIFY: begin
                if (vcnt_q != CNT_FULL) begin
                    vcnt_d     = vcnt_q + CNT_W'(1);
                    ones_ver_d = ones_ver_q + CNT_W'(ccff_tail);
                end
                if (vcnt_d == CNT_FULL) begin
                    state_d = S_DONE;
                    done_d  = 1'b1;
                    pass_d  = (ones_ver_d == ones_load_q);
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge prog_clk) begin
        if (prog_reset) begin
            state_q     <= S_IDLE;
            buf_q       <= '0;
            buf_vld_q   <= 1'b0;
            idx_q       <= '0;
            bit_cnt_q   <= '0;
            vcnt_q      <= '0;
            ones_load_q <= '0;
            ones_ver_q  <= '0;
            verify_q    <= 1'b0;
            head_q      <= 1'b0;
            load_en_q   <= 1'b0;
            done_q      <= 1'b0;
            pass_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            buf_q       <= buf_d;
            buf_vld_q   <= buf_vld_d;
            idx_q       <= idx_d;
            bit_cnt_q   <= bit_cnt_d;
            vcnt_q      <= vcnt_d;
            ones_load_q <= ones_load_d;
            ones_ver_q  <= ones_ver_d;
            verify_q    <= verify_d;
            head_q      <= head_d;
            load_en_q   <= load_en_d;
            done_q      <= done_d;
            pass_q      <= pass_d;
        end
    end

endmodule

// File: tb/tb_ccff_chain_loader.sv
// tb/tb_ccff_chain_loader.sv - Randomised self-checking bench for ccff_chain_loader with a chain model.
module tb_ccff_chain_loader;

    localparam int L  = 9;
    localparam int W  = 8;
    localparam int NW = (L + W - 1) / W;

    logic         prog_clk = 1'b0;
    logic         prog_reset, cfg_start, cfg_verify_en, cfg_valid;
    logic [W-1:0] cfg_word;
    logic         cfg_ready, ccff_head, ccff_tail, ccff_clk_en, cfg_busy, cfg_done, cfg_pass;

    ccff_chain_loader #(.CHAIN_LEN(L), .WORD_W(W)) dut (
        .prog_clk(prog_clk), .prog_reset(prog_reset), .cfg_start(cfg_start),
        .cfg_verify_en(cfg_verify_en), .cfg_word(cfg_word), .cfg_valid(cfg_valid),
        .cfg_ready(cfg_ready), .ccff_head(ccff_head), .ccff_tail(ccff_tail),
        .ccff_clk_en(ccff_clk_en), .cfg_busy(cfg_busy), .cfg_done(cfg_done), .cfg_pass(cfg_pass)
    );

    always #5 prog_clk = ~prog_clk;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Chain model: head enters at the MSB, tail is bit 0; inject flips flops for fault tests.
    logic [L-1:0] chain    = '0;
    logic [L-1:0] inject   = '0;
    logic [L-1:0] head_seq = '0;
    logic         mon_clr  = 1'b1;
    int           mon_shifts = 0;

    assign ccff_tail = chain[0];

    always @(posedge prog_clk) begin
        chain <= (ccff_clk_en ? {ccff_head, chain[L-1:1]} : chain) ^ inject;
        if (mon_clr) begin
            mon_shifts <= 0;
            head_seq   <= '0;
        end else if (ccff_clk_en) begin
            if (mon_shifts < L) head_seq[mon_shifts] <= ccff_head;
            mon_shifts <= mon_shifts + 1;
        end
    end

    logic [W-1:0] words [NW];

    function automatic logic [L-1:0] ref_stream();
        logic [L-1:0] s;
        logic [W-1:0] w;
        for (int k = 0; k < L; k++) begin
            w    = words[k / W];
            s[k] = w[k % W];
        end
        return s;
    endfunction

    task automatic run(input string nm, input bit ver, input int gap_pct,
                       input bit flip, input bit poke, input bit abort);
        int           widx = 0;
        int           cyc  = 0;
        bit           acc  = 0, flipped = 0, p1 = 0, p2 = 0;
        logic [L-1:0] exp_s = ref_stream();
        @(negedge prog_clk);
        cfg_start = 1'b1; cfg_verify_en = ver; cfg_valid = 1'b0; mon_clr = 1'b1;
        @(negedge prog_clk);
        cfg_start = 1'b0; mon_clr = 1'b0;
        while (!cfg_done && cyc < 400) begin
            cfg_start = 1'b0;
            inject    = '0;
            if (acc) begin
                widx++;
                cfg_valid = 1'b0;
            end
            if (!cfg_valid && widx < NW && $urandom_range(0, 99) >= gap_pct) begin
                cfg_valid = 1'b1;
                cfg_word  = words[widx];
            end
            acc = cfg_valid && cfg_ready;
            if (abort && mon_shifts == 4) begin
                prog_reset = 1'b1; cfg_valid = 1'b0;
                @(negedge prog_clk);
                chk({nm, "_rst_clk_en"}, 32'(ccff_clk_en), 0);
                chk({nm, "_rst_busy"},   32'(cfg_busy), 0);
                chk({nm, "_rst_done"},   32'(cfg_done), 0);
                chk({nm, "_rst_ready"},  32'(cfg_ready), 0);
                prog_reset = 1'b0;
                return;
            end
            if (poke && !p1 && mon_shifts == 4) begin
                cfg_start = 1'b1; cfg_verify_en = ~ver; p1 = 1;
                chk({nm, "_busy_mid"}, 32'(cfg_busy), 1);
                chk({nm, "_done_mid"}, 32'(cfg_done), 0);
            end
            if (poke && ver && !p2 && mon_shifts == L + 3) begin
                cfg_start = 1'b1; cfg_verify_en = ~ver; p2 = 1;
            end
            if (flip && !flipped && mon_shifts == L) begin
                inject  = L'(1) << 4;
                flipped = 1;
            end
            @(negedge prog_clk);
            cyc++;
        end
        cfg_valid = 1'b0; cfg_start = 1'b0; inject = '0;
        chk({nm, "_done"},   32'(cfg_done), 1);
        chk({nm, "_shifts"}, 32'(mon_shifts), ver ? 2 * L : L);
        chk({nm, "_heads"},  32'(head_seq), 32'(exp_s));
        if (!flip) chk({nm, "_chain"}, 32'(chain), 32'(exp_s));
        chk({nm, "_pass"},   32'(cfg_pass), (!ver || !flip) ? 1 : 0);
        chk({nm, "_ready"},  32'(cfg_ready), 0);
        chk({nm, "_busy"},   32'(cfg_busy), 0);
        chk({nm, "_clk_en"}, 32'(ccff_clk_en), 0);
    endtask

    initial begin
        prog_reset = 1'b1; cfg_start = 1'b0; cfg_verify_en = 1'b0;
        cfg_valid  = 1'b0; cfg_word  = '0;
        repeat (3) @(negedge prog_clk);
        chk("rst_ready",  32'(cfg_ready), 0);
        chk("rst_head",   32'(ccff_head), 0);
        chk("rst_clk_en", 32'(ccff_clk_en), 0);
        chk("rst_busy",   32'(cfg_busy), 0);
        chk("rst_done",   32'(cfg_done), 0);
        chk("rst_pass",   32'(cfg_pass), 0);
        prog_reset = 1'b0;

        words[0] = 8'hA5; words[1] = 8'h01;
        run("a5_ver", 1, 0, 0, 0, 0);
        chk("a5_chain_const", 32'(chain), 32'(9'b1_1010_0101));
        run("a5_gaps", 1, 50, 0, 0, 0);
        run("a5_flip", 1, 0, 1, 0, 0);
        chk("a5_flip_done", 32'(cfg_done), 1);

        words[0] = 8'hFF; words[1] = 8'hFF;
        run("ff_nover", 0, 0, 0, 0, 0);

        words[0] = 8'($urandom); words[1] = 8'($urandom);
        run("abort", 1, 0, 0, 0, 1);
        run("reload", 1, 20, 0, 0, 0);

        words[0] = 8'($urandom); words[1] = 8'($urandom);
        run("poke_v", 1, 30, 0, 1, 0);
        run("poke_n", 0, 30, 0, 1, 0);

        for (int i = 0; i < 6; i++) begin
            words[0] = 8'($urandom); words[1] = 8'($urandom);
            run($sformatf("rnd%0d", i), 1'($urandom), int'($urandom_range(0, 60)),
                0, 1'($urandom), 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
